// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the issue/writeback register tracking logic.
package cpu_pkg;

    // Default architectural register address width (32 registers).
    localparam int unsigned CPU_ADDR_W = 5;

    // Hard-wired zero register: never tracked as busy, never written.
    localparam int unsigned CPU_ZERO_REG = 31;

    typedef logic [CPU_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder_n.sv
// Enabled N-to-2^N one-hot decoder; all outputs low when disabled.
module decoder_n #(
    parameter int unsigned ADDR_W = 5
) (
    output logic [2**ADDR_W-1:0] out,
    input  logic [ADDR_W-1:0]    in,
    input  logic                 en
);

    // Raise exactly the addressed line when enabled.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: flags RAW/WAW hazards at issue, tracks in-flight
// writes and produces a registered one-hot register-file write enable.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = CPU_ADDR_W,
    parameter int unsigned ZERO_REG  = CPU_ZERO_REG,
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = $clog2(2**ADDR_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_regwrite,
    input  logic [ADDR_W-1:0]    issue_rd,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    input  logic                 RegWrite,
    input  logic [ADDR_W-1:0]    wb_rd,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] wr_en,
    output logic [2**ADDR_W-1:0] busy,
    output logic [CNT_W-1:0]     busy_count
);

    localparam int unsigned NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREG-1:0]  clr_vec;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  eff_vec;
    logic [NREG-1:0]  busy_d;
    logic [CNT_W-1:0] busy_count_d;
    logic             clr_en;
    logic             issue_fire;
    logic             inc;
    logic             dec;

    // Gating the enable keeps the zero register out of the clear vector.
    assign clr_en = RegWrite & (wb_rd != ZERO_ADDR);

    decoder_n #(
        .ADDR_W (ADDR_W)
    ) u_clr_dec (
        .out (clr_vec),
        .in  (wb_rd),
        .en  (clr_en)
    );

    // Effective busy view seen by issue, with optional same-cycle writeback bypass.
    always_comb begin
        eff_vec = busy;
        if (WB_BYPASS) begin
            eff_vec = busy & ~clr_vec;
        end
        eff_vec[ZERO_REG] = 1'b0;
    end

    // Hazard check and issue acceptance for the presented instruction.
    always_comb begin
        stall      = issue_valid &
                     (eff_vec[rs1] | eff_vec[rs2] | (issue_regwrite & eff_vec[issue_rd]));
        issue_fire = issue_valid & issue_regwrite & ~stall & (issue_rd != ZERO_ADDR);
    end

    decoder_n #(
        .ADDR_W (ADDR_W)
    ) u_set_dec (
        .out (set_vec),
        .in  (issue_rd),
        .en  (issue_fire)
    );

    // Next busy state and occupancy count; a new writer wins over a same-cycle clear.
    always_comb begin
        busy_d       = (busy & ~clr_vec) | set_vec;
        inc          = |(set_vec & ~busy);
        dec          = |(clr_vec & busy & ~set_vec);
        busy_count_d = busy_count + CNT_W'(inc) - CNT_W'(dec);
    end

    // State registers; reset overrides any set or clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            wr_en      <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_d;
            wr_en      <= clr_vec;
            busy_count <= busy_count_d;
        end
    end

endmodule
